// File: rtl/vga_pkg.sv
// vga_pkg
//   Shared VGA 640x480 @ 60 Hz timing constants: default visible/porch/sync
//   widths, line and frame totals, derived sync window bounds, the counter
//   width and a window-decode helper. Imported by the timing generator and
//   by the downstream pixel generators so both agree on the raster geometry.
package vga_pkg;

    localparam int VGA_CNT_W = 11;

    typedef logic [VGA_CNT_W-1:0] vga_cnt_t;

    localparam int VGA_H_VIS   = 640;
    localparam int VGA_H_FP    = 16;
    localparam int VGA_H_SYNC  = 96;
    localparam int VGA_H_BP    = 48;
    localparam int VGA_H_TOTAL = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int VGA_V_VIS   = 480;
    localparam int VGA_V_FP    = 10;
    localparam int VGA_V_SYNC  = 2;
    localparam int VGA_V_BP    = 33;
    localparam int VGA_V_TOTAL = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int VGA_H_SYNC_START = VGA_H_VIS + VGA_H_FP;
    localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
    localparam int VGA_V_SYNC_START = VGA_V_VIS + VGA_V_FP;
    localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

    // Half-open window test: lo <= x < hi.
    function automatic logic in_window(input vga_cnt_t x, input vga_cnt_t lo,
                                       input vga_cnt_t hi);
        return (x >= lo) && (x < hi);
    endfunction

endpackage

// File: rtl/vga_timing_if.sv
// vga_timing_if
//   Raster timing bundle produced by vga_timing.
//     pix_en      one-clk strobe per pixel period
//     hcount      pixel column
//     vcount      line
//     blank       1 outside the visible area
//     hsync/vsync active-low sync pulses
//     frame_start one-clk pulse on the wrap to (0,0)
//     frame_cnt   8-bit frame counter (only with VGA_FRAME_CNT_EN defined)
//   master: the timing generator. slave: raster consumers.
interface vga_timing_if;
    import vga_pkg::*;

    logic     pix_en;
    vga_cnt_t hcount;
    vga_cnt_t vcount;
    logic     blank;
    logic     hsync;
    logic     vsync;
    logic     frame_start;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt;

    modport master (output pix_en, hcount, vcount, blank, hsync, vsync,
                    frame_start, frame_cnt);
    modport slave  (input  pix_en, hcount, vcount, blank, hsync, vsync,
                    frame_start, frame_cnt);
`else
    modport master (output pix_en, hcount, vcount, blank, hsync, vsync,
                    frame_start);
    modport slave  (input  pix_en, hcount, vcount, blank, hsync, vsync,
                    frame_start);
`endif

endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
//   One raster axis: mod-TOTAL counter with enable, wrap flag, next-value
//   active decode and registered active-low sync decode.
//     clk, rst_n  clock, asynchronous active-low reset
//     en          advance the counter this clock
//     count       registered count, 0..TOTAL-1
//     wrap        combinational: en is high and count is at TOTAL-1
//     active_nxt  combinational: next count lies in the visible region
//     sync_n      registered: low while count lies in [SYNC_START, SYNC_END)
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int TOTAL      = VGA_H_TOTAL,
    parameter int VIS        = VGA_H_VIS,
    parameter int SYNC_START = VGA_H_SYNC_START,
    parameter int SYNC_END   = VGA_H_SYNC_END
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     en,
    output vga_cnt_t count,
    output logic     wrap,
    output logic     active_nxt,
    output logic     sync_n
);

    vga_cnt_t count_nxt;

    assign wrap = en && (count == vga_cnt_t'(TOTAL - 1));

    always_comb begin
        count_nxt = count;
        if (en) begin
            count_nxt = wrap ? '0 : count + vga_cnt_t'(1);
        end
    end

    // Decodes look at the next value so the registered outputs line up with
    // the count they describe rather than lagging it by one clock.
    assign active_nxt = (count_nxt < vga_cnt_t'(VIS));

    // Stage boundary: counter and sync register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            sync_n <= 1'b1;
        end else begin
            count  <= count_nxt;
            sync_n <= !in_window(count_nxt, vga_cnt_t'(SYNC_START),
                                 vga_cnt_t'(SYNC_END));
        end
    end

endmodule

// File: rtl/vga_timing.sv
// vga_timing
//   640x480 @ 60 Hz VGA raster timing generator. A clock divider produces the
//   pixel strobe; two chained axis counters produce hcount/vcount with
//   aligned blank and active-low hsync/vsync. Every output is a flop.
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     vif    vga_timing_if.master: pix_en, hcount, vcount, blank, hsync,
//            vsync, frame_start (+ frame_cnt)
//   Optional: define VGA_FRAME_CNT_EN to add the 8-bit frame_cnt output, which
//   counts frame_start pulses modulo 256.
//   CLK_DIV must be 1 or 2.
module vga_timing
    import vga_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int H_VIS   = VGA_H_VIS,
    parameter int H_FP    = VGA_H_FP,
    parameter int H_SYNC  = VGA_H_SYNC,
    parameter int H_BP    = VGA_H_BP,
    parameter int V_VIS   = VGA_V_VIS,
    parameter int V_FP    = VGA_V_FP,
    parameter int V_SYNC  = VGA_V_SYNC,
    parameter int V_BP    = VGA_V_BP
) (
    input  logic         clk,
    input  logic         rst_n,
    vga_timing_if.master vif
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    logic     div;
    logic     div_last;
    logic     pix_en;
    vga_cnt_t hcount;
    vga_cnt_t vcount;
    logic     h_wrap;
    logic     v_wrap;
    logic     h_active_nxt;
    logic     v_active_nxt;
    logic     hsync;
    logic     vsync;
    logic     blank;
    logic     frame_start;

    // With CLK_DIV=1 the divider is permanently at its last phase, so pix_en
    // stays high from the first clock after reset.
    assign div_last = (CLK_DIV == 1) ? 1'b1 : div;

    // Stage boundary: pixel divider
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div    <= 1'b0;
            pix_en <= 1'b0;
        end else begin
            div    <= (CLK_DIV == 1) ? 1'b0 : ~div;
            pix_en <= div_last;
        end
    end

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .VIS        (H_VIS),
        .SYNC_START (H_VIS + H_FP),
        .SYNC_END   (H_VIS + H_FP + H_SYNC)
    ) u_hcnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (pix_en),
        .count      (hcount),
        .wrap       (h_wrap),
        .active_nxt (h_active_nxt),
        .sync_n     (hsync)
    );

    // h_wrap already carries pix_en, so the line counter steps exactly once
    // per horizontal wrap.
    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .VIS        (V_VIS),
        .SYNC_START (V_VIS + V_FP),
        .SYNC_END   (V_VIS + V_FP + V_SYNC)
    ) u_vcnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (h_wrap),
        .count      (vcount),
        .wrap       (v_wrap),
        .active_nxt (v_active_nxt),
        .sync_n     (vsync)
    );

    // Stage boundary: blank and frame pulse, aligned with the counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            blank       <= !(h_active_nxt && v_active_nxt);
            frame_start <= v_wrap;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt;

    // Steps on the same edge that raises frame_start, so the new count is
    // visible together with the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= 8'd0;
        end else if (v_wrap) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

    assign vif.frame_cnt = frame_cnt;
`endif

    assign vif.pix_en      = pix_en;
    assign vif.hcount      = hcount;
    assign vif.vcount      = vcount;
    assign vif.blank       = blank;
    assign vif.hsync       = hsync;
    assign vif.vsync       = vsync;
    assign vif.frame_start = frame_start;

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing
//   Three instances share one clock: A = default timing, CLK_DIV=2;
//   B = default timing, CLK_DIV=1; C = reduced raster (15x10), CLK_DIV=1,
//   used for whole-frame behaviour. Expected outputs come from an arithmetic
//   raster model: pixels elapsed since reset release, split into column/line.
module tb_vga_timing;
    import vga_pkg::*;

    typedef struct packed {
        logic        pix_en;
        logic [10:0] h;
        logic [10:0] v;
        logic        blank;
        logic        hsync;
        logic        vsync;
        logic        fs;
    } snap_t;

    typedef struct {
        int d;
        int hvis, hfp, hsync, hbp;
        int vvis, vfp, vsync, vbp;
    } cfg_t;

    logic clk   = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    logic rst_c = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    vga_timing_if ifa ();
    vga_timing_if ifb ();
    vga_timing_if ifc ();

    vga_timing #(.CLK_DIV(2)) dut_a (.clk(clk), .rst_n(rst_a), .vif(ifa));
    vga_timing #(.CLK_DIV(1)) dut_b (.clk(clk), .rst_n(rst_b), .vif(ifb));
    vga_timing #(
        .CLK_DIV(1), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VIS(5), .V_FP(2), .V_SYNC(2), .V_BP(1)
    ) dut_c (.clk(clk), .rst_n(rst_c), .vif(ifc));

    function automatic cfg_t get_cfg(input int c);
        cfg_t k;
        case (c)
            0:       k = '{2, 640, 16, 96, 48, 480, 10, 2, 33};
            1:       k = '{1, 640, 16, 96, 48, 480, 10, 2, 33};
            default: k = '{1, 8, 2, 3, 2, 5, 2, 2, 1};
        endcase
        return k;
    endfunction

    // n = clock edges since rst_n rose (0 = in reset / before first edge).
    // The pixel strobe first samples high on edge D+1, then every D edges,
    // so pixels elapsed = (n-1)/D.
    function automatic snap_t model(input int c, input int n);
        cfg_t  k;
        snap_t e;
        int ht, vt, p, pp, h, v;
        k  = get_cfg(c);
        ht = k.hvis + k.hfp + k.hsync + k.hbp;
        vt = k.vvis + k.vfp + k.vsync + k.vbp;
        p  = (n >= 1) ? (n - 1) / k.d : 0;
        pp = (n >= 2) ? (n - 2) / k.d : 0;
        h  = p % ht;
        v  = (p / ht) % vt;
        e.pix_en = (n >= k.d) && (n % k.d == 0);
        e.h      = 11'(h);
        e.v      = 11'(v);
        e.blank  = (h >= k.hvis) || (v >= k.vvis);
        e.hsync  = !((h >= k.hvis + k.hfp) && (h < k.hvis + k.hfp + k.hsync));
        e.vsync  = !((v >= k.vvis + k.vfp) && (v < k.vvis + k.vfp + k.vsync));
        e.fs     = (p != pp) && (p % (ht * vt) == 0);
        return e;
    endfunction

    function automatic snap_t obs(input int c);
        snap_t s;
        case (c)
            0: s = '{ifa.pix_en, ifa.hcount, ifa.vcount, ifa.blank, ifa.hsync, ifa.vsync, ifa.frame_start};
            1: s = '{ifb.pix_en, ifb.hcount, ifb.vcount, ifb.blank, ifb.hsync, ifb.vsync, ifb.frame_start};
            default: s = '{ifc.pix_en, ifc.hcount, ifc.vcount, ifc.blank, ifc.hsync, ifc.vsync, ifc.frame_start};
        endcase
        return s;
    endfunction

    function automatic string fmt(input snap_t s);
        return $sformatf("pe=%b h=%0d v=%0d blank=%b hs=%b vs=%b fs=%b",
                         s.pix_en, s.h, s.v, s.blank, s.hsync, s.vsync, s.fs);
    endfunction

    task automatic set_rst(input int c, input logic val);
        case (c)
            0:       rst_a = val;
            1:       rst_b = val;
            default: rst_c = val;
        endcase
    endtask

    // Returns at the falling edge on which rst_n was released (n = 0).
    task automatic do_reset(input int c, input int hold);
        @(negedge clk);
        set_rst(c, 1'b0);
        repeat (hold) @(negedge clk);
        set_rst(c, 1'b1);
    endtask

    task automatic test_reset();
        snap_t o, e;
        int n = 0;
        int first_pe = -1;
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        repeat (5 + $urandom_range(0, 3)) @(negedge clk);
        o = obs(0); e = model(0, 0);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL reset_hold got %s required %s", fmt(o), fmt(e));
        end
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        #1;
        o = obs(0);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL reset_release got %s required %s", fmt(o), fmt(e));
        end
        repeat (12) begin
            @(posedge clk); n++; @(negedge clk);
            o = obs(0); e = model(0, n);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_startup n=%0d got %s required %s", n, fmt(o), fmt(e));
            end
            if (o.pix_en && first_pe < 0) first_pe = n;
        end
        checks++;
        if (first_pe !== 2) begin
            errors++;
            $display("FAIL first_pix_en got edge %0d required edge 2", first_pe);
        end
    endtask

    task automatic test_line_sweep();
        snap_t o, e, prev;
        int n = 0;
        bit bad = 0;
        int blank_h = -1, blank_v = -1;
        int hs_fall_h = -1, hs_fall_n = -1, hs_rise_h = -1, hs_rise_n = -1;
        int w1_n = -1, w1_v = -1, w2_n = -1;
        do_reset(0, $urandom_range(2, 6));
        prev = obs(0);
        repeat (3300) begin
            @(posedge clk); n++; @(negedge clk);
            o = obs(0); e = model(0, n);
            if (!bad) begin
                checks++;
                if (o !== e) begin
                    errors++; bad = 1;
                    $display("FAIL line_model n=%0d got %s required %s", n, fmt(o), fmt(e));
                end
            end
            if (blank_h < 0 && !prev.blank && o.blank) begin blank_h = int'(o.h); blank_v = int'(o.v); end
            if (hs_fall_h < 0 && prev.hsync && !o.hsync) begin hs_fall_h = int'(o.h); hs_fall_n = n; end
            if (hs_fall_h >= 0 && hs_rise_h < 0 && !prev.hsync && o.hsync) begin
                hs_rise_h = int'(o.h); hs_rise_n = n;
            end
            if (prev.h == 11'd799 && o.h == 11'd0) begin
                if (w1_n < 0) begin w1_n = n; w1_v = int'(o.v); end
                else if (w2_n < 0) w2_n = n;
            end
            prev = o;
        end
        checks++;
        if (blank_h !== 640 || blank_v !== 0) begin
            errors++;
            $display("FAIL blank_rise got (%0d,%0d) required (640,0)", blank_h, blank_v);
        end
        checks++;
        if (hs_fall_h !== 656) begin
            errors++;
            $display("FAIL hsync_fall got h=%0d required h=656", hs_fall_h);
        end
        checks++;
        if (hs_rise_h !== 752) begin
            errors++;
            $display("FAIL hsync_rise got h=%0d required h=752", hs_rise_h);
        end
        checks++;
        if (hs_rise_n - hs_fall_n !== 96 * 2) begin
            errors++;
            $display("FAIL hsync_width got %0d clocks required %0d", hs_rise_n - hs_fall_n, 96 * 2);
        end
        checks++;
        if (w1_v !== 1) begin
            errors++;
            $display("FAIL line_wrap_vcount got v=%0d required v=1", w1_v);
        end
        checks++;
        if (w2_n - w1_n !== 800 * 2) begin
            errors++;
            $display("FAIL line_length got %0d clocks required %0d", w2_n - w1_n, 800 * 2);
        end
    endtask

    task automatic test_clk_div1();
        snap_t o, e, prev;
        int n = 0;
        bit bad = 0;
        int pe_low = 0, w1 = -1, w2 = -1;
        do_reset(1, $urandom_range(2, 6));
        prev = obs(1);
        repeat (1700) begin
            @(posedge clk); n++; @(negedge clk);
            o = obs(1); e = model(1, n);
            if (!bad) begin
                checks++;
                if (o !== e) begin
                    errors++; bad = 1;
                    $display("FAIL div1_model n=%0d got %s required %s", n, fmt(o), fmt(e));
                end
            end
            if (o.pix_en !== 1'b1) pe_low++;
            if (prev.h == 11'd799 && o.h == 11'd0) begin
                if (w1 < 0) w1 = n;
                else if (w2 < 0) w2 = n;
            end
            prev = o;
        end
        checks++;
        if (pe_low !== 0) begin
            errors++;
            $display("FAIL div1_pix_en got %0d low clocks required 0", pe_low);
        end
        checks++;
        if (w2 - w1 !== 800) begin
            errors++;
            $display("FAIL div1_line_length got %0d clocks required 800", w2 - w1);
        end
    endtask

    task automatic test_frame_sweep();
        cfg_t  k;
        snap_t o, e, prev;
        int n = 0;
        bit bad = 0;
        int ht, vt, frame_clk;
        int fsq[$];
        int blank_bad = 0, vs_bad = 0, vs_low = 0, wrap_bad = 0;
        bit vlow;
        k = get_cfg(2);
        ht = k.hvis + k.hfp + k.hsync + k.hbp;
        vt = k.vvis + k.vfp + k.vsync + k.vbp;
        frame_clk = ht * vt * k.d;
        do_reset(2, $urandom_range(2, 6));
        prev = obs(2);
        repeat (3 * frame_clk + 20) begin
            @(posedge clk); n++; @(negedge clk);
            o = obs(2); e = model(2, n);
            if (!bad) begin
                checks++;
                if (o !== e) begin
                    errors++; bad = 1;
                    $display("FAIL frame_model n=%0d got %s required %s", n, fmt(o), fmt(e));
                end
            end
            if (int'(o.v) >= k.vvis && !o.blank) blank_bad++;
            vlow = (int'(o.v) >= k.vvis + k.vfp) && (int'(o.v) < k.vvis + k.vfp + k.vsync);
            if (o.vsync === vlow) vs_bad++;
            if (!o.vsync) vs_low++;
            if (o.fs) begin
                fsq.push_back(n);
                if (!(o.h == 11'd0 && o.v == 11'd0 &&
                      int'(prev.h) == ht - 1 && int'(prev.v) == vt - 1)) wrap_bad++;
            end
            prev = o;
        end
        checks++;
        if (fsq.size() !== 3) begin
            errors++;
            $display("FAIL frame_start_count got %0d required 3", fsq.size());
        end
        for (int i = 1; i < fsq.size(); i++) begin
            checks++;
            if (fsq[i] - fsq[i-1] !== frame_clk) begin
                errors++;
                $display("FAIL frame_period got %0d clocks required %0d", fsq[i] - fsq[i-1], frame_clk);
            end
        end
        checks++;
        if (wrap_bad !== 0) begin
            errors++;
            $display("FAIL simultaneous_wrap got %0d bad pulses required 0", wrap_bad);
        end
        checks++;
        if (blank_bad !== 0) begin
            errors++;
            $display("FAIL vblank got %0d unblanked clocks required 0", blank_bad);
        end
        checks++;
        if (vs_bad !== 0 || vs_low !== 3 * k.vsync * ht * k.d) begin
            errors++;
            $display("FAIL vsync_window got %0d bad / %0d low clocks required 0 / %0d",
                     vs_bad, vs_low, 3 * k.vsync * ht * k.d);
        end
    endtask

    task automatic test_mid_frame_reset();
        snap_t o, e;
        int n = 0;
        bit bad = 0;
        bit found = 0;
        // Reduced raster: reset at a random point well inside the frame.
        do_reset(2, 2);
        repeat ($urandom_range(40, 140)) begin
            @(posedge clk); n++; @(negedge clk);
            o = obs(2); e = model(2, n);
            if (!bad) begin
                checks++;
                if (o !== e) begin
                    errors++; bad = 1;
                    $display("FAIL pre_reset_small n=%0d got %s required %s", n, fmt(o), fmt(e));
                end
            end
        end
        #2 rst_c = 1'b0;
        #1 o = obs(2); e = model(2, 0);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL async_reset_small got %s required %s", fmt(o), fmt(e));
        end
        repeat (2) @(negedge clk);
        rst_c = 1'b1;
        n = 0; bad = 0;
        repeat (200) begin
            @(posedge clk); n++; @(negedge clk);
            o = obs(2); e = model(2, n);
            if (!bad) begin
                checks++;
                if (o !== e) begin
                    errors++; bad = 1;
                    $display("FAIL restart_small n=%0d got %s required %s", n, fmt(o), fmt(e));
                end
            end
        end
        // Full raster: reset while sitting on column 300 of line 1.
        do_reset(0, 3);
        n = 0;
        for (int i = 0; i < 4000 && !found; i++) begin
            @(posedge clk); n++; @(negedge clk);
            o = obs(0);
            if (o.h == 11'd300 && o.v == 11'd1) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reach_300_1 got last %s required h=300 v=1", fmt(o));
        end
        #2 rst_a = 1'b0;
        #1 o = obs(0); e = model(0, 0);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL async_reset_full got %s required %s", fmt(o), fmt(e));
        end
        repeat (3) @(negedge clk);
        rst_a = 1'b1;
        n = 0; bad = 0;
        repeat (1700) begin
            @(posedge clk); n++; @(negedge clk);
            o = obs(0); e = model(0, n);
            if (!bad) begin
                checks++;
                if (o !== e) begin
                    errors++; bad = 1;
                    $display("FAIL restart_full n=%0d got %s required %s", n, fmt(o), fmt(e));
                end
            end
        end
    endtask

`ifdef VGA_FRAME_CNT_EN
    task automatic test_frame_cnt();
        cfg_t k;
        int n = 0;
        int frames = 0;
        int limit;
        k = get_cfg(2);
        limit = 257 * (k.hvis + k.hfp + k.hsync + k.hbp) * (k.vvis + k.vfp + k.vsync + k.vbp) * k.d + 50;
        do_reset(2, 3);
        checks++;
        if (ifc.frame_cnt !== 8'd0) begin
            errors++;
            $display("FAIL frame_cnt_reset got %0d required 0", ifc.frame_cnt);
        end
        for (int i = 0; i < limit && frames < 257; i++) begin
            @(posedge clk); n++; @(negedge clk);
            if (model(2, n).fs) begin
                frames++;
                if (frames >= 255) begin
                    checks++;
                    if (ifc.frame_cnt !== 8'(frames % 256)) begin
                        errors++;
                        $display("FAIL frame_cnt frame %0d got %0d required %0d",
                                 frames, ifc.frame_cnt, frames % 256);
                    end
                end
            end
        end
        checks++;
        if (frames !== 257 || ifc.frame_cnt !== 8'd1) begin
            errors++;
            $display("FAIL frame_cnt_257 got frames=%0d cnt=%0d required frames=257 cnt=1",
                     frames, ifc.frame_cnt);
        end
    endtask
`endif

    initial begin
        #1_500_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_line_sweep();
        test_clk_div1();
        test_frame_sweep();
        test_mid_frame_reset();
`ifdef VGA_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
# vga_timing

Generates 640x480 @ 60 Hz VGA raster timing: horizontal/vertical pixel counters, blanking, and active-low sync pulses. Sits directly upstream of the background/sprite pixel generators, which consume `hcount`, `vcount` and `blank` combinationally to produce `r`, `g`, `b`. `hsync` and `vsync` go straight to the connector, time-aligned with the counters.

## Interface
- `CLK_DIV`, 2: system clocks per pixel; 1 or 2 only. 2 suits a 50 MHz board clock giving a 25 MHz pixel rate.
- `H_VIS`, 640; `H_FP`, 16; `H_SYNC`, 96; `H_BP`, 48: horizontal visible pixels, front porch, sync width and back porch. Line total is 800.
- `V_VIS`, 480; `V_FP`, 10; `V_SYNC`, 2; `V_BP`, 33: vertical visible lines, front porch, sync width and back porch. Frame total is 525.

- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `pix_en`  out  1  one-`clk` strobe marking each pixel period
- `hcount`  out  11  current pixel column, 0..799
- `vcount`  out  11  current line, 0..524
- `blank`  out  1  1 outside the visible area
- `hsync`  out  1  active-low horizontal sync
- `vsync`  out  1  active-low vertical sync
- `frame_start`  out  1  one-`clk` pulse when the counters wrap to (0,0)

## Operation
- **Divider:**
  - `div` counts 0..`CLK_DIV`-1 and wraps.
  - `pix_en` = (`div` == `CLK_DIV`-1), registered.
  - With `CLK_DIV`=1, `pix_en` is constantly 1 after reset.
- **Horizontal counter:**
  - On `pix_en`, `hcount` increments.
  - At 799 it wraps to 0.
- **Vertical counter:**
  - On `pix_en` with `hcount`==799, `vcount` increments.
  - At 524 it wraps to 0.
- **Decoded outputs:** registered, computed from the next-state counter values so they align exactly with `hcount`/`vcount`.
  - `blank` = (h ≥ 640) || (v ≥ 480).
  - `hsync` = 0 iff 656 ≤ h < 752.
  - `vsync` = 0 iff 490 ≤ v < 492.
- **`frame_start`:**
  - Asserts for exactly one `clk` in the cycle where (`hcount`,`vcount`) becomes (0,0) via wrap.
  - It does not assert out of reset.
- **Widths:**
  - Counters are 11-bit unsigned.
  - Boundary constants are derived from the parameters, e.g. sync start = `H_VIS`+`H_FP`.
  - There is no signed arithmetic.
- **Reset values:**
  - `div`=0, `pix_en`=0, `hcount`=0, `vcount`=0.
  - `blank`=0, `hsync`=1, `vsync`=1, `frame_start`=0.
- **Reset mid-frame:** counters return to (0,0) immediately (asynchronous assertion). Counting restarts from (0,0) on the first `pix_en` after deassertion.

## Timing
- All outputs are registered, with zero combinational paths from inputs to outputs.
- Counters update on the `clk` edge that samples `pix_en`=1. Each value holds for `CLK_DIV` clocks.
- **First pixel after reset:**
  - `pix_en` first asserts on `clk` edge `CLK_DIV` after `rst_n` rises.
  - `hcount` becomes 1 one edge later.
  - Pixel (0,0) is therefore held slightly longer than nominal after reset only.
- **Line/frame timing:**
  - Line period: 800×`CLK_DIV` clocks.
  - Frame period: 420 000×`CLK_DIV` clocks.
- `hsync` low duration: 96 pixels. `vsync` low duration: 2 lines (1600 pixels).
- **Simultaneous wrap:** at (799,524) both counters wrap on the same edge, and `frame_start` pulses on that edge.

## Configuration
- `VGA_FRAME_CNT_EN`:
  - When defined, adds output port `frame_cnt` (out, 8 bits, reset 0).
  - It increments, modulo 256, on every `frame_start`.
  - Used for animation timing downstream.
- Undefined: the port and register are absent, and behaviour is otherwise identical.

## Structure
- **Package `vga_pkg`** holds:
  - the default timing constants (visible, porch and sync widths, totals);
  - the counter width `VGA_CNT_W`=11;
  - derived sync start/end constants shared with the pixel generators.
- **Sub-module `vga_axis_counter`** is a natural split: a parameterised mod-N counter with enable, wrap flag, and registered active/sync decode. It is instantiated twice, with the horizontal wrap flag chaining into the vertical enable.

## Test plan
- **Reset:** hold `rst_n`=0 for 5 clocks, then release. Before the first `pix_en`, require `hcount`=0, `vcount`=0, `blank`=0, `hsync`=1, `vsync`=1, `frame_start`=0. With `CLK_DIV`=2, `pix_en` strobes every second clock.
- **Line sweep:** run one line.
  - `blank` rises when `hcount`=640.
  - `hsync` falls at 656 and rises at 752.
  - `hcount` wraps 799→0 with `vcount` 0→1.
  - Line length is exactly 1600 clocks.
- **Frame sweep:** run one full frame.
  - `blank` stays high for all of `vcount` 480..524.
  - `vsync` is low for exactly `vcount` 490..491.
  - `frame_start` pulses once at the (799,524)→(0,0) transition, 840 000 clocks after the previous pulse.
- **Mid-frame reset:** assert `rst_n` at (300,200) → the counters read (0,0) asynchronously and `hsync`/`vsync`=1. After release, the counting sequence restarts cleanly.
- **`CLK_DIV`=1:** `pix_en` is constantly 1 after reset, and the line period is 800 clocks.
- **`VGA_FRAME_CNT_EN`:** run 257 frames → `frame_cnt` reads 1 after wrapping through 255→0.
